// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: default datapath width, per-bit
// generate/propagate pair and a constant-foldable ceil(log2) helper.
package arith_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prefix_level.sv
// One Kogge-Stone prefix level: combines each (G, P) pair with the pair DIST
// bits below it; bits below DIST pass through unchanged.
module prefix_level
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DIST  = 1
) (
    input  pg_t [WIDTH-1:0] pg_i,
    output pg_t [WIDTH-1:0] pg_o
);

    always_comb begin
        pg_o = pg_i;
        for (int unsigned i = DIST; i < WIDTH; i++) begin
            pg_o[i].g = pg_i[i].g | (pg_i[i].p & pg_i[i-DIST].g);
            pg_o[i].p = pg_i[i].p & pg_i[i-DIST].p;
        end
    end

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor: pg front end, one registered stage
// per prefix level, registered sum stage; a single global stall freezes all.
module prefix_adder_pipe
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned LEVELS = clog2(WIDTH);

    logic stall;

    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] t0_d;
    logic             c0_d;
    pg_t  [WIDTH-1:0] pg0_d;

    logic [LEVELS:0]  v_q;
    logic [LEVELS:0]  c0_q;
    logic [WIDTH-1:0] t_q   [0:LEVELS];
    pg_t  [WIDTH-1:0] pg_q  [0:LEVELS];
    pg_t  [WIDTH-1:0] lvl_d [1:LEVELS];

    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~stall;

    // Carry-in is folded into bit 0's generate so the prefix tree needs no extra column.
    always_comb begin
        bb   = sub ? ~b : b;
        c0_d = sub | cin;
        t0_d = a ^ bb;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pg0_d[i].g = a[i] & bb[i];
            pg0_d[i].p = a[i] | bb[i];
        end
        pg0_d[0].g = pg0_d[0].g | (pg0_d[0].p & c0_d);
    end

    for (genvar k = 1; k <= int'(LEVELS); k++) begin : g_level
        prefix_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << (k - 1))
        ) u_level (
            .pg_i (pg_q[k-1]),
            .pg_o (lvl_d[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
        end else if (!stall) begin
            v_q <= {v_q[LEVELS-1:0], in_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            pg_q[0] <= pg0_d;
            t_q[0]  <= t0_d;
            c0_q    <= {c0_q[LEVELS-1:0], c0_d};
            for (int unsigned k = 1; k <= LEVELS; k++) begin
                pg_q[k] <= lvl_d[k];
                t_q[k]  <= t_q[k-1];
            end
        end
    end

    // After the last level G[i] is the carry out of bit i, including carry-in.
    always_comb begin
        carry[0] = c0_q[LEVELS];
        for (int unsigned i = 1; i < WIDTH; i++) begin
            carry[i] = pg_q[LEVELS][i-1].g;
        end
        sum_d  = t_q[LEVELS] ^ carry;
        cout_d = pg_q[LEVELS][WIDTH-1].g;
        ovf_d  = carry[WIDTH-1] ^ cout_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (!stall) begin
            out_valid_q <= v_q[LEVELS];
            if (v_q[LEVELS]) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Scoreboard bench for prefix_adder_pipe at WIDTH=16: expected results are
// queued at accept time and compared, with latency, when results retire.
module tb_prefix_adder_pipe;

    localparam int LAT = 6;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          acc_cyc;
        int          acc_stall;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   stalls = 0;

    prefix_adder_pipe #(
        .WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: plain 17-bit addition; MSB carry-in from a 15-bit partial sum.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic su);
        logic [15:0] yy;
        logic [16:0] full;
        logic [15:0] low;
        logic        c;
        yy   = su ? ~y : y;
        c    = su ? 1'b1 : ci;
        full = {1'b0, x} + {1'b0, yy} + 17'(c);
        low  = {1'b0, x[14:0]} + {1'b0, yy[14:0]} + 16'(c);
        return {low[15] ^ full[16], full[16], full[15:0]};
    endfunction

    task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic tci,
                        input logic tsu, input logic [15:0] es, input logic ec, input logic eo);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        a = ta; b = tb_; cin = tci; sub = tsu; in_valid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (in_ready && !rst) begin
                ok = 1'b1;
                sb.push_back('{es, ec, eo, cyc, stalls});
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic        rs;
        logic [17:0] m;
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom);
        rs = 1'($urandom);
        m  = model(ra, rb, rc, rs);
        send(ra, rb, rc, rs, m[15:0], m[16], m[17]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("result_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("sum", sum, e.s);
                    check("cout", cout, e.c);
                    check("ovf", ovf, e.o);
                    if (stalls == e.acc_stall) check("latency", cyc - e.acc_cyc, LAT);
                end
            end
            if (out_valid && !out_ready) stalls++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] held;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        send(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        drain();
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        send(16'h1357, 16'h1357, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        drain();

        fork
            begin
                for (int i = 0; i < 20; i++) send_rand();
            end
            begin
                repeat (10) @(negedge clk);
                @(posedge clk);
                #1 out_ready = 1'b0;
                held = sum;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0);
                    check("stall_out_valid", out_valid, 1);
                    check("stall_sum_hold", sum, held);
                    if (i < 4) @(posedge clk);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        for (int i = 0; i < 4; i++) send_rand();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("flush_out_valid", out_valid, 0);
        check("flush_sum", sum, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("flush_no_result", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
